bbox_multi: RTL and testbench
=============================

BBOX_MULTI -- requirements
Module: bbox_multi

Interface
REQ-001 The block SHALL have parameter IMG_W, default 1280, meaning active pixels per line.
REQ-002 The block SHALL have parameter IMG_H, default 720, meaning active lines per frame.
REQ-003 The block SHALL have parameter COORD_W, default 11, meaning coordinate width; 2^COORD_W > max(IMG_W, IMG_H).
REQ-004 The block SHALL have parameter N_CH, default 4, meaning number of independent mask channels.
REQ-005 The block SHALL have parameter CNT_W, default 21, meaning per-channel pixel counter width.
REQ-006 The block SHALL have parameter MIN_PIX, default 16, meaning minimum mask-pixel count for a valid box.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-008 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 The block SHALL have port de, input, 1 bit: data enable, pixel valid.
REQ-010 The block SHALL have port hsync, input, 1 bit: ignored; retained for pin compatibility.
REQ-011 The block SHALL have port vsync, input, 1 bit: vertical sync, active-high.
REQ-012 The block SHALL have port mask, input, N_CH bits: per-channel mask bit for the current pixel.
REQ-013 The block SHALL have ports left, right, up, down, each an output of N_CH*COORD_W bits: per-channel box edges; channel k occupies bits [k*COORD_W +: COORD_W].
REQ-014 The block SHALL have port count, output, N_CH*CNT_W bits: per-channel mask-pixel count of the last frame.
REQ-015 The block SHALL have port valid, output, N_CH bits: per-channel flag, set when the last frame's count >= MIN_PIX and count > 0.
REQ-016 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when results update.

Function
REQ-017 Position: x and y SHALL both be 0 while vsync=1; with de=1 and vsync=0, x SHALL increment per pixel.
REQ-018 On the de 1->0 transition (vsync=0), x SHALL return to 0 and y SHALL increment, saturating at IMG_H-1; x SHALL saturate at IMG_W-1 if de stays high longer than IMG_W cycles.
REQ-019 Accumulation: per channel k, with de=1, vsync=0 and mask[k]=1, the block SHALL apply min/max updates to x (left/right) and y (up/down), and SHALL increment the count, saturating at 2^CNT_W-1.
REQ-020 Channels SHALL be fully independent: same pixel, any subset of mask bits, no interaction.
REQ-021 End-of-frame (eof) SHALL occur on the cycle where prev_vsync=0 and vsync=1; prev_vsync SHALL register vsync every cycle.
REQ-022 On eof, each channel's accumulators SHALL be copied to the result registers, and the accumulators SHALL be reinitialised: left/up to all-ones, right/down to 0, count to 0.
REQ-023 On eof, for a channel with count=0, the block SHALL latch left=right=up=down=0 and valid=0, not the sentinel values.
REQ-024 On eof, valid[k] SHALL be set to (count>=MIN_PIX) and (count>0); the edges and count SHALL be latched regardless of valid.
REQ-025 Latency: outputs and frame_done SHALL change on the clock edge following the cycle where eof is sampled; frame_done SHALL be high for exactly one cycle; outputs SHALL hold until the next eof.
REQ-026 No accumulation SHALL occur on the eof cycle, because vsync=1 gates it; eof and pixel updates therefore SHALL never collide.
REQ-027 A frame shorter than IMG_H lines SHALL be reported normally; y saturation SHALL not block eof.

Reset
REQ-028 While rst=1, the block SHALL set x, y, accumulators (sentinels), count, left/right/up/down outputs to 0, valid to 0, and frame_done to 0.
REQ-029 While rst=1, prev_vsync SHALL be set to 1, so the first vsync level after reset SHALL never create a spurious eof.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; the first eof after reset SHALL report only pixels seen after reset.
REQ-031 rst SHALL take priority over eof and accumulation in the same cycle.

Verification (IMG_W=8, IMG_H=4, N_CH=2, MIN_PIX=2, COORD_W=4)
REQ-032 The bench SHALL drive ch0 mask at (2,1),(5,3), then vsync rise -> next cycle ch0 left=2, right=5, up=1, down=3, count=2, valid=1, and frame_done a 1-cycle pulse.
REQ-033 The bench SHALL drive a single ch1 pixel at (7,0) -> ch1 edges 7/7/0/0, count=1, valid=0; ch0 in the same frame with no pixels -> all 0, valid=0.
REQ-034 The bench SHALL drive both channels set on every pixel of a full frame -> both report 0/7/0/3, count=32, valid=1.
REQ-035 The bench SHALL assert rst after ch0 pixel (1,1), then drive pixel (6,2) and eof -> ch0 left=right=6, up=down=2, count=1.
REQ-036 The bench SHALL drive de high for 10 cycles with mask high throughout -> right=7 (x saturation), and the next line SHALL still start at x=0.
REQ-037 The bench SHALL drive two consecutive frames with different boxes -> outputs change only one cycle after each vsync rise and hold steady in between.

Source files
------------

// File: rtl/bbox_multi.sv
// bbox_multi: per-channel mask bounding boxes and pixel counts, reported once per frame
//   in : clk, rst (sync, active-high), de, hsync (unused), vsync (active-high), mask[N_CH]
//   out: left/right/up/down (COORD_W per channel), count (CNT_W per channel),
//        valid[N_CH], frame_done (one-cycle pulse when results update)
module bbox_multi #(
  parameter int IMG_W   = 1280,
  parameter int IMG_H   = 720,
  parameter int COORD_W = 11,
  parameter int N_CH    = 4,
  parameter int CNT_W   = 21,
  parameter int MIN_PIX = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     de,
  input  logic                     hsync,
  input  logic                     vsync,
  input  logic [N_CH-1:0]          mask,
  output logic [N_CH*COORD_W-1:0]  left,
  output logic [N_CH*COORD_W-1:0]  right,
  output logic [N_CH*COORD_W-1:0]  up,
  output logic [N_CH*COORD_W-1:0]  down,
  output logic [N_CH*CNT_W-1:0]    count,
  output logic [N_CH-1:0]          valid,
  output logic                     frame_done
);
  localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0]   MIN_CNT = CNT_W'(MIN_PIX);
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic prev_de_q, prev_vs_q, fd_q;
  logic [N_CH-1:0][COORD_W-1:0] al_q, al_d, ar_q, ar_d, au_q, au_d, ad_q, ad_d;
  logic [N_CH-1:0][COORD_W-1:0] rl_q, rl_d, rr_q, rr_d, ru_q, ru_d, rd_q, rd_d;
  logic [N_CH-1:0][CNT_W-1:0] ac_q, ac_d, rc_q, rc_d;
  logic [N_CH-1:0] val_q, val_d, hit;
  logic eof, pix, line_end, unused_hsync;
  assign unused_hsync = hsync;
  assign eof      = !prev_vs_q && vsync;
  assign pix      = de && !vsync;
  assign line_end = !vsync && !de && prev_de_q;
  assign hit      = mask & {N_CH{pix}};
  assign left  = rl_q;
  assign right = rr_q;
  assign up    = ru_q;
  assign down  = rd_q;
  assign count = rc_q;
  assign valid = val_q;
  assign frame_done = fd_q;
  always_comb begin
    x_d = (vsync || line_end) ? '0 : (de && x_q != X_MAX) ? x_q + 1'b1 : x_q;
    y_d = vsync ? '0 : (line_end && y_q != Y_MAX) ? y_q + 1'b1 : y_q;
    al_d = al_q; ar_d = ar_q; au_d = au_q; ad_d = ad_q; ac_d = ac_q;
    rl_d = rl_q; rr_d = rr_q; ru_d = ru_q; rd_d = rd_q; rc_d = rc_q; val_d = val_q;
    for (int k = 0; k < N_CH; k++) begin
      // vsync gates accumulation, so eof and a pixel hit never coincide
      al_d[k] = eof ? '1 : (hit[k] && x_q < al_q[k]) ? x_q : al_q[k];
      ar_d[k] = eof ? '0 : (hit[k] && x_q > ar_q[k]) ? x_q : ar_q[k];
      au_d[k] = eof ? '1 : (hit[k] && y_q < au_q[k]) ? y_q : au_q[k];
      ad_d[k] = eof ? '0 : (hit[k] && y_q > ad_q[k]) ? y_q : ad_q[k];
      ac_d[k] = eof ? '0 : (hit[k] && !(&ac_q[k])) ? ac_q[k] + 1'b1 : ac_q[k];
      // an empty channel reports zeros rather than the min/max sentinels
      rl_d[k]  = eof ? ((ac_q[k] != '0) ? al_q[k] : '0) : rl_q[k];
      rr_d[k]  = eof ? ((ac_q[k] != '0) ? ar_q[k] : '0) : rr_q[k];
      ru_d[k]  = eof ? ((ac_q[k] != '0) ? au_q[k] : '0) : ru_q[k];
      rd_d[k]  = eof ? ((ac_q[k] != '0) ? ad_q[k] : '0) : rd_q[k];
      rc_d[k]  = eof ? ac_q[k] : rc_q[k];
      val_d[k] = eof ? (ac_q[k] != '0 && ac_q[k] >= MIN_CNT) : val_q[k];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      prev_de_q <= 1'b0;
      prev_vs_q <= 1'b1;
      al_q <= '1;
      ar_q <= '0;
      au_q <= '1;
      ad_q <= '0;
      ac_q <= '0;
      rl_q <= '0;
      rr_q <= '0;
      ru_q <= '0;
      rd_q <= '0;
      rc_q <= '0;
      val_q <= '0;
      fd_q <= 1'b0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      prev_de_q <= de;
      prev_vs_q <= vsync;
      al_q <= al_d;
      ar_q <= ar_d;
      au_q <= au_d;
      ad_q <= ad_d;
      ac_q <= ac_d;
      rl_q <= rl_d;
      rr_q <= rr_d;
      ru_q <= ru_d;
      rd_q <= rd_d;
      rc_q <= rc_d;
      val_q <= val_d;
      fd_q <= eof;
    end
  end
endmodule

// File: tb/tb_bbox_multi.sv
// tb_bbox_multi: scoreboard bench for bbox_multi on a small 8x4 two-channel image
module tb_bbox_multi;
  localparam int W = 8, H = 4, N = 2, CW = 4, CNW = 21, MP = 2;
  logic clk = 1'b0;
  logic rst, de, hsync, vsync;
  logic [N-1:0] mask;
  logic [N*CW-1:0] left, right, up, down;
  logic [N*CNW-1:0] count;
  logic [N-1:0] valid;
  logic frame_done;
  int n_vec = 0, n_err = 0;
  typedef struct {
    logic [N*CW-1:0]  l, r, u, d;
    logic [N*CNW-1:0] c;
    logic [N-1:0]     v;
  } res_t;
  res_t sb[$];
  res_t last;
  int ml[N], mr[N], mu[N], md[N], mc[N];
  logic [N-1:0] pat [H][W];

  always #5 clk = ~clk;

  bbox_multi #(.IMG_W(W), .IMG_H(H), .COORD_W(CW), .N_CH(N), .CNT_W(CNW), .MIN_PIX(MP)) dut (
    .clk(clk), .rst(rst), .de(de), .hsync(hsync), .vsync(vsync), .mask(mask),
    .left(left), .right(right), .up(up), .down(down), .count(count),
    .valid(valid), .frame_done(frame_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      ml[k] = 1 << 20; mr[k] = 0; mu[k] = 1 << 20; md[k] = 0; mc[k] = 0;
    end
  endtask

  task automatic clr_pat();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        pat[y][x] = '0;
  endtask

  task automatic drive_line(input int y, input int len);
    for (int i = 0; i < len; i++) begin
      int xx;
      xx = (i < W) ? i : W - 1;
      de = 1'b1;
      mask = pat[y][xx];
      for (int k = 0; k < N; k++)
        if (mask[k]) begin
          if (xx < ml[k]) ml[k] = xx;
          if (xx > mr[k]) mr[k] = xx;
          if (y < mu[k]) mu[k] = y;
          if (y > md[k]) md[k] = y;
          mc[k]++;
        end
      tick();
    end
    de = 1'b0;
    mask = '0;
    hsync = 1'b1;
    tick();
    hsync = 1'b0;
    tick();
  endtask

  task automatic start_frame();
    vsync = 1'b0;
    de = 1'b0;
    mask = '0;
    model_clear();
    tick();
    tick();
  endtask

  task automatic drive_frame(input int lines, input int len);
    for (int y = 0; y < lines; y++) drive_line(y, len);
  endtask

  task automatic end_frame(input string name);
    res_t e, g;
    for (int k = 0; k < N; k++) begin
      e.l[k*CW +: CW] = mc[k] != 0 ? CW'(ml[k]) : '0;
      e.r[k*CW +: CW] = mc[k] != 0 ? CW'(mr[k]) : '0;
      e.u[k*CW +: CW] = mc[k] != 0 ? CW'(mu[k]) : '0;
      e.d[k*CW +: CW] = mc[k] != 0 ? CW'(md[k]) : '0;
      e.c[k*CNW +: CNW] = CNW'(mc[k]);
      e.v[k] = mc[k] >= MP && mc[k] > 0;
    end
    sb.push_back(e);
    vsync = 1'b1;
    @(negedge clk);
    n_vec++;
    if (frame_done !== 1'b0 || left !== last.l || right !== last.r || up !== last.u ||
        down !== last.d || count !== last.c || valid !== last.v) begin
      n_err++;
      $display("FAIL %s hold-before-update: fd=%b l=%h r=%h u=%h d=%h c=%h v=%b, required fd=0 l=%h r=%h u=%h d=%h c=%h v=%b",
               name, frame_done, left, right, up, down, count, valid,
               last.l, last.r, last.u, last.d, last.c, last.v);
    end
    @(negedge clk);
    n_vec++;
    if (frame_done !== 1'b1) begin
      n_err++;
      $display("FAIL %s frame_done: got %b, required 1", name, frame_done);
    end
    g = sb.pop_front();
    n_vec++;
    if (left !== g.l) begin n_err++; $display("FAIL %s left: got %h, required %h", name, left, g.l); end
    n_vec++;
    if (right !== g.r) begin n_err++; $display("FAIL %s right: got %h, required %h", name, right, g.r); end
    n_vec++;
    if (up !== g.u) begin n_err++; $display("FAIL %s up: got %h, required %h", name, up, g.u); end
    n_vec++;
    if (down !== g.d) begin n_err++; $display("FAIL %s down: got %h, required %h", name, down, g.d); end
    n_vec++;
    if (count !== g.c) begin n_err++; $display("FAIL %s count: got %h, required %h", name, count, g.c); end
    n_vec++;
    if (valid !== g.v) begin n_err++; $display("FAIL %s valid: got %b, required %b", name, valid, g.v); end
    last = g;
    @(negedge clk);
    n_vec++;
    if (frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL %s frame_done pulse width: got %b one cycle later, required 0", name, frame_done);
    end
  endtask

  task automatic check_zero(input string name);
    n_vec++;
    if (left !== '0 || right !== '0 || up !== '0 || down !== '0 || count !== '0 ||
        valid !== '0 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL %s: l=%h r=%h u=%h d=%h c=%h v=%b fd=%b, required all 0",
               name, left, right, up, down, count, valid, frame_done);
    end
  endtask

  task automatic test_reset();
    int seen;
    rst = 1'b1; de = 1'b0; hsync = 1'b0; vsync = 1'b0; mask = '0;
    last = '{default: '0};
    tick();
    tick();
    @(negedge clk);
    check_zero("reset_outputs");
    tick();
    rst = 1'b0;
    vsync = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (frame_done) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL spurious_eof_after_reset: frame_done high %0d cycles, required 0", seen);
    end
  endtask

  task automatic test_basic();
    clr_pat();
    pat[1][2] = 2'b01;
    pat[3][5] = 2'b01;
    start_frame();
    drive_frame(H, W);
    end_frame("basic");
  endtask

  task automatic test_single();
    clr_pat();
    pat[0][7] = 2'b10;
    start_frame();
    drive_frame(H, W);
    end_frame("single_ch1");
  endtask

  task automatic test_full();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        pat[y][x] = 2'b11;
    start_frame();
    drive_frame(H, W);
    end_frame("full_frame");
  endtask

  task automatic test_rst_mid();
    clr_pat();
    pat[1][1] = 2'b01;
    start_frame();
    drive_line(0, W);
    drive_line(1, W);
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check_zero("mid_frame_reset_outputs");
    last = '{default: '0};
    model_clear();
    tick();
    rst = 1'b0;
    tick();
    clr_pat();
    pat[2][6] = 2'b01;
    drive_frame(3, W);
    end_frame("after_reset");
  endtask

  task automatic test_xsat();
    clr_pat();
    for (int x = 0; x < W; x++) pat[0][x] = 2'b01;
    pat[1][0] = 2'b10;
    start_frame();
    drive_line(0, 10);
    drive_line(1, W);
    end_frame("x_saturation");
  endtask

  task automatic test_back_to_back();
    clr_pat();
    pat[0][1] = 2'b01;
    pat[2][3] = 2'b11;
    start_frame();
    drive_frame(H, W);
    end_frame("b2b_frame_a");
    clr_pat();
    pat[1][4] = 2'b10;
    pat[3][6] = 2'b11;
    pat[2][0] = 2'b01;
    start_frame();
    drive_frame(2, W);
    @(negedge clk);
    n_vec++;
    if (left !== last.l || right !== last.r || count !== last.c || valid !== last.v) begin
      n_err++;
      $display("FAIL b2b_mid_frame_hold: l=%h r=%h c=%h v=%b, required l=%h r=%h c=%h v=%b",
               left, right, count, valid, last.l, last.r, last.c, last.v);
    end
    tick();
    drive_line(2, W);
    drive_line(3, W);
    end_frame("b2b_frame_b");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_full();
    test_rst_mid();
    test_xsat();
    test_back_to_back();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
